// File: rtl/minx_bridge_pkg.sv
// Shared encodings for the minx memory-side bridge: bus status codes, region map,
// region and cartridge FSM enums, and the address decoder.
package minx_bridge_pkg;

  localparam logic [1:0] BUS_IDLE      = 2'd0;
  localparam logic [1:0] BUS_IRQ_READ  = 2'd1;
  localparam logic [1:0] BUS_MEM_WRITE = 2'd2;
  localparam logic [1:0] BUS_MEM_READ  = 2'd3;

  localparam logic [23:0] BIOS_BASE  = 24'h000000;
  localparam logic [23:0] BIOS_LIMIT = 24'h000FFF;
  localparam logic [23:0] RAM_BASE   = 24'h001000;
  localparam logic [23:0] RAM_LIMIT  = 24'h001FFF;
  localparam logic [23:0] IO_BASE    = 24'h002000;
  localparam logic [23:0] IO_LIMIT   = 24'h0020FF;
  localparam logic [23:0] CART_BASE  = 24'h002100;
  localparam logic [23:0] CART_LIMIT = 24'h1FFFFF;

  localparam int          RAM_AW   = 12;
  localparam int          CART_AW  = 21;
  localparam logic [20:0] CART_TOP = 21'h1FFFFF;

  typedef enum logic [2:0] {
    REG_BIOS,
    REG_RAM,
    REG_IO,
    REG_CART,
    REG_OPEN
  } region_t;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    PF
  } cart_state_t;

  // Regions are contiguous from address 0, so upper limits alone pick the region.
  function automatic region_t decode_region(input logic [23:0] addr);
    if (addr <= BIOS_LIMIT)      return REG_BIOS;
    else if (addr <= RAM_LIMIT)  return REG_RAM;
    else if (addr <= IO_LIMIT)   return REG_IO;
    else if (addr <= CART_LIMIT) return REG_CART;
    else                         return REG_OPEN;
  endfunction

endpackage

// File: rtl/minx_bridge_ram.sv
// Internal 4 KB single-port RAM: write on the enabled edge, registered read data.
// Contents are deliberately not reset.
module minx_bridge_ram
  import minx_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [RAM_AW-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [0:(1<<RAM_AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/minx_bus_bridge.sv
// Memory-side bridge below the minx bus: BIOS ROM, internal RAM and cartridge SDRAM.
// Define MINX_BRIDGE_PREFETCH_EN to add the one-entry sequential cartridge read prefetch.
module minx_bus_bridge
  import minx_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_ce,
  input  logic [23:0] bus_address,
  input  logic [7:0]  bus_wdata,
  input  logic        bus_read,
  input  logic        bus_write,
  input  logic [1:0]  bus_status,
  output logic [7:0]  bus_data_in,
  output logic [11:0] bios_addr,
  input  logic [7:0]  bios_rdata,
  output logic        cart_req,
  output logic        cart_we,
  output logic [20:0] cart_addr,
  output logic [7:0]  cart_wdata,
  input  logic        cart_ack,
  input  logic [7:0]  cart_rdata,
  output logic        late
);

  logic        acc, is_cart, issue;
  region_t     region, resp_src_p0;
  logic        resp_vld_p0;
  logic [7:0]  ram_rdata;
  logic        pend_vld, pend_we;
  logic [20:0] pend_addr;
  logic [7:0]  pend_wdata;
  cart_state_t state, state_d;
  logic        req_d, we_d;
  logic [20:0] addr_d;
  logic [7:0]  wdata_d;
  logic        pf_hit, pf_abandon;
  logic [7:0]  buf_data;

  assign acc     = clk_ce && (bus_read || bus_write) && (bus_status != BUS_IRQ_READ);
  assign region  = decode_region(bus_address);
  assign is_cart = acc && (region == REG_CART);
  assign issue   = (state == IDLE) && pend_vld;

  minx_bridge_ram u_ram (
    .clk   (clk),
    .we    (acc && bus_write && (region == REG_RAM)),
    .re    (acc && !bus_write && (region == REG_RAM)),
    .addr  (bus_address[RAM_AW-1:0]),
    .wdata (bus_wdata),
    .rdata (ram_rdata)
  );

`ifdef MINX_BRIDGE_PREFETCH_EN
  localparam bit PF_EN = 1'b1;
  logic        pf_kill, pf_fill, buf_vld;
  logic [20:0] buf_addr;

  // Any bus activity during PF (this cycle or earlier) means the speculative data is stale or unwanted.
  assign pf_abandon = pf_kill || pend_vld || acc;
  assign pf_fill    = (state == PF) && cart_req && cart_ack && !pf_abandon;
  assign pf_hit     = buf_vld && !pend_we && (pend_addr == buf_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pf_kill <= 1'b0;
      buf_vld <= 1'b0;
    end else begin
      pf_kill <= (state_d == PF) && (pf_kill || acc);
      if (pf_fill) buf_vld <= 1'b1;
      else if (is_cart && bus_write && (bus_address[20:0] == buf_addr)) buf_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (pf_fill) begin
      buf_addr <= cart_addr;
      buf_data <= cart_rdata;
    end
  end
`else
  localparam bit PF_EN = 1'b0;
  assign pf_abandon = 1'b1;
  assign pf_hit     = 1'b0;
  assign buf_data   = 8'h00;
`endif

  // Stage p0: the sampling edge captures the access; responses land one edge later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_vld_p0 <= 1'b0;
      bios_addr   <= '0;
      pend_vld    <= 1'b0;
      late        <= 1'b0;
    end else begin
      resp_vld_p0 <= acc && !bus_write && (region != REG_CART);
      if (acc && !bus_write && (region == REG_BIOS)) bios_addr <= bus_address[11:0];
      if (is_cart) pend_vld <= 1'b1;
      else if (issue) pend_vld <= 1'b0;
      if (acc && ((state == RD) || (state == WR))) late <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    resp_src_p0 <= region;
    if (is_cart) begin
      pend_we    <= bus_write;
      pend_addr  <= bus_address[20:0];
      pend_wdata <= bus_wdata;
    end
  end

  // Stage p1: newest response wins if a local read and a cartridge completion coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_data_in <= '0;
    end else if (resp_vld_p0) begin
      case (resp_src_p0)
        REG_BIOS: bus_data_in <= bios_rdata;
        REG_RAM:  bus_data_in <= ram_rdata;
        REG_IO:   bus_data_in <= 8'h00;
        default:  bus_data_in <= 8'hFF;
      endcase
    end else if (issue && pf_hit) begin
      bus_data_in <= buf_data;
    end else if ((state == RD) && cart_ack) begin
      bus_data_in <= cart_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (pend_vld && !pf_hit) state_d = pend_we ? WR : RD;
      RD:   if (cart_ack) state_d = (PF_EN && (cart_addr != CART_TOP)) ? PF : IDLE;
      WR:   if (cart_ack) state_d = IDLE;
      PF:   if (cart_req ? cart_ack : pf_abandon) state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d   = cart_req;
    we_d    = cart_we;
    addr_d  = cart_addr;
    wdata_d = cart_wdata;
    case (state)
      IDLE: if (pend_vld && !pf_hit) begin
        req_d   = 1'b1;
        we_d    = pend_we;
        addr_d  = pend_addr;
        wdata_d = pend_wdata;
      end
      RD, WR: if (cart_ack) req_d = 1'b0;
      PF: begin
        if (cart_req) begin
          if (cart_ack) req_d = 1'b0;
        end else if (!pf_abandon) begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = cart_addr + 21'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cart_req   <= 1'b0;
      cart_we    <= 1'b0;
      cart_addr  <= '0;
      cart_wdata <= '0;
    end else begin
      cart_req   <= req_d;
      cart_we    <= we_d;
      cart_addr  <= addr_d;
      cart_wdata <= wdata_d;
    end
  end

endmodule
